mux4_piso_seq: RTL and testbench

Parallel-to-serial sequencer that sits directly upstream of the 4:1 bit-select mux. It accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 2-bit select through all four positions, one position per downstream-accepted beat. The mux output is the serial stream, framed by `ser_valid`/`ser_last`.

---
 rtl/mux4_piso_seq.sv | 67 ++++++
 tb/tb_mux4_piso_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_piso_seq.sv
// mux4_piso_seq: holds a 4-bit word on a 4:1 mux and steps its select to serialise it.
// Optional MUX4_PISO_BACK2BACK_EN: accept the next word on the last beat, removing the idle bubble.
module mux4_piso_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  input  logic       ser_ready,
  output logic       ser_valid,
  output logic       ser_last,
  output logic [3:0] mux_I,
  output logic [1:0] mux_s,
  output logic [7:0] word_cnt
);

  localparam logic [1:0] SEL_START = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] SEL_LAST  = MSB_FIRST ? 2'd0 : 2'd3;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;

  logic last_beat;
  logic load;

  function automatic logic [1:0] next_sel(input logic [1:0] s);
    return MSB_FIRST ? (s - 2'd1) : (s + 2'd1);
  endfunction

  assign ser_valid = (state == SHIFT);
  assign ser_last  = ser_valid && (mux_s == SEL_LAST);
  assign last_beat = ser_last && ser_ready;

`ifdef MUX4_PISO_BACK2BACK_EN
  // The last beat frees the word register, so a new word can land on the same edge.
  assign load_ready = (state == IDLE) || last_beat;
`else
  assign load_ready = (state == IDLE);
`endif

  assign load = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mux_I    <= 4'd0;
      mux_s    <= SEL_START;
      word_cnt <= 8'd0;
    end else begin
      if (last_beat) begin
        word_cnt <= word_cnt + 8'd1;
      end
      if (load) begin
        mux_I <= load_data;
        mux_s <= SEL_START;
        state <= SHIFT;
      end else if (last_beat) begin
        state <= IDLE;
      end else if (ser_valid && ser_ready) begin
        mux_s <= next_sel(mux_s);
      end
    end
  end

endmodule

// File: tb/tb_mux4_piso_seq.sv
// Bench for mux4_piso_seq: LSB-first and MSB-first instances checked every cycle against a
// bit-position model, plus hand-computed scenarios for streams, stalls, gaps, reset and wrap.
module tb_mux4_piso_seq;

`ifdef MUX4_PISO_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'd0;
  logic       ser_ready = 1'b0;

  logic       a_ready, a_valid, a_last;
  logic [3:0] a_I;
  logic [1:0] a_s;
  logic [7:0] a_cnt;
  logic       b_ready, b_valid, b_last;
  logic [3:0] b_I;
  logic [1:0] b_s;
  logic [7:0] b_cnt;

  mux4_piso_seq #(.MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_ready), .ser_ready(ser_ready), .ser_valid(a_valid), .ser_last(a_last),
    .mux_I(a_I), .mux_s(a_s), .word_cnt(a_cnt)
  );

  mux4_piso_seq #(.MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_ready), .ser_ready(ser_ready), .ser_valid(b_valid), .ser_last(b_last),
    .mux_I(b_I), .mux_s(b_s), .word_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: busy flag, held word, and how many bits of it have already been sent.
  bit         m_busy = 1'b0;
  logic [3:0] m_w = 4'd0;
  int         m_k = 0;
  logic [7:0] m_cnt = 8'd0;
  int         m_words = 0;

  wire m_lastbeat = m_busy && ser_ready && (m_k == 3);
  wire m_acc      = load_valid && (!m_busy || (B2B && m_lastbeat));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_w    <= 4'd0;
      m_k    <= 0;
      m_cnt  <= 8'd0;
    end else begin
      if (m_lastbeat) begin
        m_cnt   <= m_cnt + 8'd1;
        m_words <= m_words + 1;
      end
      if (m_acc) begin
        m_w    <= load_data;
        m_k    <= 0;
        m_busy <= 1'b1;
      end else if (m_lastbeat) begin
        m_busy <= 1'b0;
      end else if (m_busy && ser_ready) begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    int exp_ready;
    exp_ready = (!m_busy || (B2B && m_busy && ser_ready && m_k == 3)) ? 1 : 0;
    chk("a_ready", a_ready, exp_ready);
    chk("b_ready", b_ready, exp_ready);
    chk("a_valid", a_valid, m_busy);
    chk("b_valid", b_valid, m_busy);
    chk("a_last", a_last, (m_busy && m_k == 3) ? 1 : 0);
    chk("b_last", b_last, (m_busy && m_k == 3) ? 1 : 0);
    chk("a_I", a_I, m_w);
    chk("b_I", b_I, m_w);
    chk("a_s", a_s, m_k);
    chk("b_s", b_s, 3 - m_k);
    chk("a_cnt", a_cnt, m_cnt);
    chk("b_cnt", b_cnt, m_cnt);
    if (m_busy) begin
      chk("a_bit", a_I[a_s], m_w[m_k]);
      chk("b_bit", b_I[b_s], m_w[3 - m_k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lit(input logic [3:0] w, input int ea[4], input int eb[4], input int cnt);
    load_valid = 1'b1;
    load_data  = w;
    ser_ready  = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lit_sa", a_s, i);
      chk("lit_bita", a_I[a_s], ea[i]);
      chk("lit_sb", b_s, 3 - i);
      chk("lit_bitb", b_I[b_s], eb[i]);
      chk("lit_last", a_last, (i == 3) ? 1 : 0);
      tick();
    end
    chk("lit_cnt", a_cnt, cnt);
    chk("lit_idle", a_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_sa", a_s, 0);
    chk("rst_sb", b_s, 3);
    chk("rst_valid", a_valid, 0);
    chk("rst_last", a_last, 0);
    chk("rst_I", a_I, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ready", a_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int ea[4];
    int eb[4];
    int acc, cyc, gaps, s_before, base;
    int acc_cyc[2];
    bit will;

    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    chk("inrst_valid", a_valid, 0);
    chk("inrst_I", a_I, 0);
    chk("inrst_sb", b_s, 3);
    load_valid = 1'b0;
    rst_n      = 1'b1;
    tick();

    ea = '{1, 1, 0, 1}; eb = '{1, 0, 1, 1};
    send_lit(4'b1011, ea, eb, 1);
    ea = '{0, 0, 0, 1}; eb = '{1, 0, 0, 0};
    send_lit(4'b1000, ea, eb, 2);

    // Stall three cycles at s=1 while offering a different word that must be ignored.
    load_valid = 1'b1;
    load_data  = 4'b0110;
    ser_ready  = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("stall_s0", a_s, 0);
    tick();
    ser_ready  = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'b1001;
    repeat (3) begin
      chk("stall_s", a_s, 1);
      chk("stall_I", a_I, 4'b0110);
      chk("stall_valid", a_valid, 1);
      chk("stall_ready", a_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    ea = '{0, 1, 1, 0};
    for (int i = 1; i < 4; i++) begin
      chk("stall_run_s", a_s, i);
      chk("stall_run_bit", a_I[a_s], ea[i]);
      tick();
    end
    chk("stall_cnt", a_cnt, 3);
    chk("stall_idle", a_valid, 0);

    // Two words with load_valid held high.
    load_valid = 1'b1;
    load_data  = 4'b1101;
    ser_ready  = 1'b1;
    acc = 0; cyc = 0; gaps = 0; s_before = -1;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    while (acc < 2 && cyc < 20) begin
      if (acc == 1 && !a_valid) gaps++;
      will = a_ready && load_valid;
      if (will && acc == 1) s_before = a_s;
      if (will) acc_cyc[acc] = cyc;
      tick();
      cyc++;
      if (will) begin
        acc++;
        if (acc == 1) load_data = 4'b0011;
        else load_valid = 1'b0;
      end
    end
    chk("b2b_accepts", acc, 2);
    chk("b2b_gaps", gaps, B2B ? 0 : 1);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], B2B ? 4 : 5);
    chk("b2b_sbefore", s_before, 3);
    chk("b2b_s_after", a_s, 0);
    chk("b2b_I", a_I, 4'b0011);
    chk("b2b_valid", a_valid, 1);
    cyc = 0;
    while (a_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("b2b_drain_timeout", a_valid, 0);
    chk("b2b_cnt", a_cnt, 5);

    // Reset in the middle of a word at s=2.
    load_valid = 1'b1;
    load_data  = 4'b1010;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("mid_s2", a_s, 2);
    do_reset();
    ea = '{1, 0, 1, 0}; eb = '{0, 1, 0, 1};
    send_lit(4'b0101, ea, eb, 1);

    // Random traffic over 256 words from reset; counter must wrap to zero.
    do_reset();
    base = m_words;
    cyc  = 0;
    while ((m_words - base) < 256 && cyc < 20000) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = 4'($urandom);
      ser_ready  = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("wrap_words", m_words - base, 256);
    chk("wrap_cnt_a", a_cnt, 0);
    chk("wrap_cnt_b", b_cnt, 0);

    load_valid = 1'b0;
    ser_ready  = 1'b1;
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
